audio_tone_gen: RTL
===================

AUDIO_TONE_GEN -- requirements
Module: audio_tone_gen

Interface
REQ-001 SHALL have parameter HALF_BASE, default 96, the half-period in sample ticks for freq index 0.
REQ-002 SHALL have parameter HALF_STEP, default 4, the half-period decrement per freq index.
REQ-003 SHALL have parameter ENV_DIV, default 16, the number of sample ticks per envelope step.
REQ-004 SHALL have port clk, input, 1 bit: system clock; the block uses one clock only.
REQ-005 SHALL have port resetN, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port sample_tick, input, 1 bit: one-cycle strobe at the codec sample rate (48 kHz nominal).
REQ-007 SHALL have port enable_sound, input, 1 bit: level from the sound-event state machine; 1 requests a tone.
REQ-008 SHALL have port freq, input, 4 bits: tone index 0..15 from the sound-event state machine.
REQ-009 SHALL have port audio_sample, output, 16 bits: signed two's-complement sample to the codec.
REQ-010 SHALL have port sample_valid, output, 1 bit: one-cycle strobe, asserted when audio_sample is updated.
REQ-011 SHALL have port busy, output, 1 bit: 1 whenever the envelope state is not S_IDLE.

Function
REQ-012 SHALL compute half_period = HALF_BASE - HALF_STEP*cur_freq as 7-bit unsigned; defaults give idx 0 -> 96 (250 Hz) and idx 15 -> 36 (~667 Hz).
REQ-013 SHALL hold phase_cnt (7-bit), polarity (1-bit), cur_freq (4-bit), amp (4-bit), env_cnt (4-bit) and a 2-bit envelope state.
REQ-014 SHALL use envelope states S_IDLE, S_ATTACK, S_SUSTAIN and S_RELEASE.
REQ-015 SHALL keep all state unchanged, and keep sample_valid at 0, in any cycle without sample_tick, except for the S_IDLE->S_ATTACK and S_RELEASE->S_ATTACK transitions.
REQ-016 SHALL, on each sample_tick when phase_cnt == half_period-1, set phase_cnt to 0, toggle polarity and load cur_freq from freq; otherwise it SHALL increment phase_cnt.
REQ-017 SHALL, in S_IDLE with enable_sound=1, move to S_ATTACK on the next clk regardless of sample_tick, and at the same time load cur_freq=freq, set phase_cnt=0, polarity=0, amp=0 and env_cnt=0.
REQ-018 SHALL, in S_ATTACK, S_SUSTAIN and S_RELEASE, increment env_cnt modulo ENV_DIV on each sample_tick; an "env step" is a sample_tick where env_cnt == ENV_DIV-1.
REQ-019 SHALL, in S_ATTACK, increment amp on each env step; when amp reaches 15 it SHALL move to S_SUSTAIN.
REQ-020 SHALL, in S_SUSTAIN, hold amp at 15 and move to S_RELEASE when enable_sound=0.
REQ-021 SHALL, in S_ATTACK with enable_sound=0, move to S_RELEASE with amp unchanged.
REQ-022 SHALL, in S_RELEASE, decrement amp on each env step; when amp reaches 0 it SHALL move to S_IDLE.
REQ-023 SHALL, in S_RELEASE with enable_sound=1, move to S_ATTACK with amp unchanged and without resetting the phase.
REQ-024 SHALL leave the phase running on a freq change while enable_sound=1; the new value takes effect only at the next polarity toggle, so there are no mid-half-period glitches.
REQ-025 SHALL compute magnitude = amp*2048, giving 0..30720 with no overflow.
REQ-026 SHALL set audio_sample = +magnitude when polarity=0 and -magnitude when polarity=1; audio_sample SHALL be 0 in S_IDLE.
REQ-027 SHALL register audio_sample and sample_valid so that sample_valid asserts exactly 1 clk after each sample_tick, with audio_sample reflecting the state updated by that tick; latency is 1 clk.
REQ-028 SHALL assert sample_valid after every sample_tick, including in S_IDLE, where it carries a sample of 0.
REQ-029 SHALL treat a sample_tick in the same cycle as an S_IDLE exit as the first tick of S_ATTACK, with phase_cnt=0 and amp=0 applied and no increment.

Reset
REQ-030 SHALL, on resetN=0 at any time, asynchronously set state=S_IDLE, phase_cnt=0, polarity=0, cur_freq=0, amp=0, env_cnt=0, audio_sample=0, sample_valid=0 and busy=0.
REQ-031 SHALL, after resetN deasserts mid-tone, produce no sound until enable_sound is sampled as 1 again.

Verification
REQ-032 SHALL verify reset during S_SUSTAIN: resetN=0 -> audio_sample=0, sample_valid=0, busy=0 immediately, without waiting for clk.
REQ-033 SHALL verify attack to sustain: enable_sound=1, freq=5 (half_period 76) -> amp reaches 15 after 240 ticks, polarity toggles every 76 ticks, samples alternate +30720/-30720.
REQ-034 SHALL verify release timing: enable_sound=0 in S_SUSTAIN -> amp decrements every 16 ticks, S_IDLE and busy=0 after 240 ticks, audio_sample=0.
REQ-035 SHALL verify a glitch-free freq change: freq 9->1 at phase_cnt=10 -> the current half-period completes at 60 ticks, the next lasts 92.
REQ-036 SHALL verify attack abort: enable_sound dropped at amp=7 in S_ATTACK -> S_RELEASE from amp 7, S_IDLE after 112 ticks; enable_sound raised at amp=3 in S_RELEASE -> S_ATTACK from amp 3.
REQ-037 SHALL verify the simultaneous start: enable_sound=1 and sample_tick in the same cycle from S_IDLE -> sample_valid the next clk with audio_sample=0, state S_ATTACK, phase_cnt=0.

Source files
------------

// File: rtl/audio_tone_gen.sv
// ---------------------------------------------------------------------------
// audio_tone_gen
//
// Square-wave tone generator with a linear attack/sustain/release envelope,
// producing one signed 16-bit sample per codec sample tick.
//
// Parameters
//   HALF_BASE : half-period in sample ticks for freq index 0
//   HALF_STEP : half-period decrement per freq index
//   ENV_DIV   : sample ticks per envelope amplitude step
//
// Ports
//   clk          : system clock (single clock domain)
//   resetN       : asynchronous active-low reset
//   sample_tick  : one-cycle strobe at the codec sample rate
//   enable_sound : level, 1 requests a tone
//   freq         : tone index 0..15
//   audio_sample : signed two's-complement sample to the codec
//   sample_valid : one-cycle strobe, 1 clk after each sample_tick
//   busy         : 1 whenever the envelope is not idle
// ---------------------------------------------------------------------------
module audio_tone_gen #(
    parameter int HALF_BASE = 96,
    parameter int HALF_STEP = 4,
    parameter int ENV_DIV   = 16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        sample_tick,
    input  logic        enable_sound,
    input  logic [3:0]  freq,
    output logic [15:0] audio_sample,
    output logic        sample_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ATTACK  = 2'd1,
        S_SUSTAIN = 2'd2,
        S_RELEASE = 2'd3
    } env_state_t;

    env_state_t         state_q,   state_d;
    logic [6:0]         phase_q,   phase_d;
    logic               pol_q,     pol_d;
    logic [3:0]         cur_freq_q, cur_freq_d;
    logic [3:0]         amp_q,     amp_d;
    logic [3:0]         env_cnt_q, env_cnt_d;
    logic signed [15:0] audio_q,   audio_d;
    logic               valid_q,   valid_d;

    logic [6:0] half_period;
    logic       phase_wrap;
    logic       env_step;

    // amp*2048 never exceeds 30720, so the magnitude fits a positive int16
    // and negation cannot overflow.
    function automatic logic signed [15:0] tone_sample(input logic [3:0] amp,
                                                       input logic       pol);
        logic signed [15:0] mag;
        mag = signed'({1'b0, amp, 11'b0});
        return pol ? -mag : mag;
    endfunction

    assign half_period = 7'(HALF_BASE - HALF_STEP * int'(cur_freq_q));
    assign phase_wrap  = (phase_q == (half_period - 7'd1));
    assign env_step    = (env_cnt_q == 4'(ENV_DIV - 1));

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        pol_d      = pol_q;
        cur_freq_d = cur_freq_q;
        amp_d      = amp_q;
        env_cnt_d  = env_cnt_q;
        audio_d    = audio_q;
        valid_d    = 1'b0;

        // Tone phase: the new freq is only picked up at a polarity toggle,
        // so a half-period is never cut short or stretched mid-way.
        if (sample_tick) begin
            if (phase_wrap) begin
                phase_d    = 7'd0;
                pol_d      = ~pol_q;
                cur_freq_d = freq;
            end else begin
                phase_d = phase_q + 7'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // Start overrides any same-cycle tick: that tick becomes
                // the first attack tick with a fresh phase and zero amp.
                if (enable_sound) begin
                    state_d    = S_ATTACK;
                    cur_freq_d = freq;
                    phase_d    = 7'd0;
                    pol_d      = 1'b0;
                    amp_d      = 4'd0;
                    env_cnt_d  = 4'd0;
                end
            end
            S_ATTACK: begin
                if (sample_tick) begin
                    env_cnt_d = env_step ? 4'd0 : env_cnt_q + 4'd1;
                    if (!enable_sound) begin
                        state_d = S_RELEASE;
                    end else if (amp_q == 4'd15) begin
                        // Re-attack from a release that had not stepped down yet.
                        state_d = S_SUSTAIN;
                    end else if (env_step) begin
                        amp_d = amp_q + 4'd1;
                        if (amp_q == 4'd14) begin
                            state_d = S_SUSTAIN;
                        end
                    end
                end
            end
            S_SUSTAIN: begin
                if (sample_tick) begin
                    env_cnt_d = env_step ? 4'd0 : env_cnt_q + 4'd1;
                    if (!enable_sound) begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (sample_tick) begin
                    env_cnt_d = env_step ? 4'd0 : env_cnt_q + 4'd1;
                end
                // Re-trigger takes effect without waiting for a tick.
                if (enable_sound) begin
                    state_d = S_ATTACK;
                end else if (sample_tick) begin
                    if (amp_q == 4'd0) begin
                        // Attack aborted before the first step.
                        state_d = S_IDLE;
                    end else if (env_step) begin
                        amp_d = amp_q - 4'd1;
                        if (amp_q == 4'd1) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Output sample reflects the state after this tick's update.
        if (sample_tick) begin
            valid_d = 1'b1;
            audio_d = (state_d == S_IDLE) ? 16'sd0 : tone_sample(amp_d, pol_d);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            phase_q    <= 7'd0;
            pol_q      <= 1'b0;
            cur_freq_q <= 4'd0;
            amp_q      <= 4'd0;
            env_cnt_q  <= 4'd0;
            audio_q    <= 16'sd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pol_q      <= pol_d;
            cur_freq_q <= cur_freq_d;
            amp_q      <= amp_d;
            env_cnt_q  <= env_cnt_d;
            audio_q    <= audio_d;
            valid_q    <= valid_d;
        end
    end

    assign audio_sample = audio_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != S_IDLE);

endmodule
